// File: rtl/breakout_pkg.sv
// Shared definitions for the Breakout game sequencer and the ball/bricks object block.
package breakout_pkg;

   // Play state encoding; values are visible on the gameState port.
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StMiss  = 3'd3,
      StWin   = 3'd4,
      StOver  = 3'd5
   } game_state_e;

   localparam int unsigned SCORE_W_DEFAULT    = 12;
   localparam int unsigned NUM_BRICKS_DEFAULT = 32;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned LIVES_W  = 3;
   localparam int unsigned BRICKS_W = 8;
   localparam int unsigned SPEED_W  = 2;
   localparam int unsigned FRAME_W  = 8;
   // Width of the serve/reload strobes exchanged with the ball/bricks block.
   localparam int unsigned STROBE_W = 1;

endpackage

// File: rtl/frame_delay_timer.sv
// Loadable frame counter: counts frame ticks while enabled and flags the tick that reaches
// the target. Clearing wins over counting, so a tick on a state change is not carried over.
module frame_delay_timer
   import breakout_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic               count_en_i,
   input  logic               tick_i,
   input  logic [FRAME_W-1:0] target_i,
   output logic               done_o
);

   logic [FRAME_W-1:0] count_q, count_d;

   // Next count and done pulse; done marks the tick that brings the count to target_i.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_en_i && tick_i) begin
         count_d = count_q + FRAME_W'(1);
      end
      done_o = count_en_i & tick_i & (count_q == (target_i - FRAME_W'(1)));
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game-level sequencer: play FSM, lives, score and brick count.
// Optional build macro LEVEL_SPEEDUP_EN enables the speedLevel ramp (tied to 0 otherwise).
module breakout_game_ctrl
   import breakout_pkg::*;
#(
   parameter int unsigned LIVES        = 3,
   parameter int unsigned NUM_BRICKS   = NUM_BRICKS_DEFAULT,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned PAUSE_FRAMES = 90,
   parameter int unsigned SCORE_W      = SCORE_W_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                frameTick,
   input  logic                launchBtn,
   input  logic                brickHit,
   input  logic                ballMissed,
   output logic [STATE_W-1:0]  gameState,
   output logic                ballEnable,
   output logic                ballServe,
   output logic                wallReload,
   output logic [LIVES_W-1:0]  livesLeft,
   output logic [SCORE_W-1:0]  score,
   output logic [BRICKS_W-1:0] bricksLeft,
   output logic [SPEED_W-1:0]  speedLevel
);

   localparam logic [LIVES_W-1:0]  LIVES_INIT  = LIVES_W'(LIVES);
   localparam logic [BRICKS_W-1:0] BRICKS_INIT = BRICKS_W'(NUM_BRICKS);
   localparam logic [FRAME_W-1:0]  SERVE_T     = FRAME_W'(SERVE_FRAMES);
   localparam logic [FRAME_W-1:0]  PAUSE_T     = FRAME_W'(PAUSE_FRAMES);

   game_state_e         state_q, state_d;
   logic                btn_q;
   logic                press, hit_ok, win_hit, miss_ok;
   logic                tmr_clr, tmr_en, tmr_done;
   logic [FRAME_W-1:0]  tmr_target;
   logic                en_q, serve_q, reload_q;
   logic [LIVES_W-1:0]  lives_q;
   logic [SCORE_W-1:0]  score_q;
   logic [BRICKS_W-1:0] bricks_q;

   // Event qualification and next-state decode; a hit that clears the wall masks a miss.
   always_comb begin
      press   = launchBtn & ~btn_q;
      hit_ok  = (state_q == StPlay) & brickHit;
      win_hit = hit_ok & (bricks_q == BRICKS_W'(1));
      miss_ok = (state_q == StPlay) & ballMissed & ~win_hit;
      state_d = state_q;
      case (state_q)
         StIdle:  if (press) state_d = StServe;
         StServe: if (press || tmr_done) state_d = StPlay;
         StPlay: begin
            if (win_hit) begin
               state_d = StWin;
            end else if (miss_ok) begin
               state_d = (lives_q == LIVES_W'(1)) ? StOver : StMiss;
            end
         end
         StMiss:  if (tmr_done) state_d = StServe;
         StWin:   if (tmr_done) state_d = StServe;
         StOver:  if (press) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      tmr_en     = (state_q == StServe) | (state_q == StMiss) | (state_q == StWin);
      tmr_target = (state_q == StMiss) ? PAUSE_T : SERVE_T;
      // Restart the phase timer on every transition so a coincident tick is not counted.
      tmr_clr    = (state_d != state_q);
   end

   frame_delay_timer u_timer (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (tmr_clr),
      .count_en_i (tmr_en),
      .tick_i     (frameTick),
      .target_i   (tmr_target),
      .done_o     (tmr_done)
   );

   // Play FSM with registered outputs and one-clock strobes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         btn_q    <= launchBtn;  // a level held through reset must not look like a press
         en_q     <= 1'b0;
         serve_q  <= 1'b0;
         reload_q <= 1'b0;
         lives_q  <= LIVES_INIT;
         score_q  <= '0;
         bricks_q <= BRICKS_INIT;
      end else begin
         btn_q    <= launchBtn;
         state_q  <= state_d;
         en_q     <= (state_d == StPlay);
         serve_q  <= 1'b0;
         reload_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (press) begin
                  reload_q <= 1'b1;
                  serve_q  <= 1'b1;
                  lives_q  <= LIVES_INIT;
                  score_q  <= '0;
                  bricks_q <= BRICKS_INIT;
               end
            end
            StPlay: begin
               if (hit_ok) begin
                  if (score_q != '1) score_q <= score_q + SCORE_W'(1);
                  if (bricks_q != '0) bricks_q <= bricks_q - BRICKS_W'(1);
               end
               if (win_hit) reload_q <= 1'b1;
               if (miss_ok) lives_q <= lives_q - LIVES_W'(1);
            end
            StMiss: begin
               if (tmr_done) serve_q <= 1'b1;
            end
            StWin: begin
               if (tmr_done) begin
                  serve_q  <= 1'b1;
                  bricks_q <= BRICKS_INIT;
               end
            end
            StOver: begin
               if (press) score_q <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef LEVEL_SPEEDUP_EN
   logic               score_wrap;
   logic [SPEED_W-1:0] speed_q;

   // A counted hit that rolls the low three score bits over marks eight more bricks.
   always_comb begin
      score_wrap = hit_ok & (score_q != '1) & (score_q[2:0] == 3'b111);
   end

   // Speed ramp: cleared at game start only, kept across MISS and WIN.
   always_ff @(posedge clock) begin
      if (reset) begin
         speed_q <= '0;
      end else if ((state_q == StIdle) && press) begin
         speed_q <= '0;
      end else if (score_wrap && (speed_q != '1)) begin
         speed_q <= speed_q + SPEED_W'(1);
      end
   end

   assign speedLevel = speed_q;
`else
   assign speedLevel = '0;
`endif

   assign gameState  = state_q;
   assign ballEnable = en_q;
   assign ballServe  = serve_q;
   assign wallReload = reload_q;
   assign livesLeft  = lives_q;
   assign score      = score_q;
   assign bricksLeft = bricks_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench for breakout_game_ctrl: vector table, directed corner sequences and
// randomized play against a behavioural game model.
module tb_breakout_game_ctrl;

   localparam int LV   = 3;
   localparam int NB   = 32;
   localparam int SF   = 4;
   localparam int PF   = 2;
   localparam int SW   = 5;
   localparam int SMAX = (1 << SW) - 1;

   logic          clock = 1'b0;
   logic          reset, frameTick, launchBtn, brickHit, ballMissed;
   logic [2:0]    gameState;
   logic          ballEnable, ballServe, wallReload;
   logic [2:0]    livesLeft;
   logic [SW-1:0] score;
   logic [7:0]    bricksLeft;
   logic [1:0]    speedLevel;

   always #5 clock = ~clock;

   breakout_game_ctrl #(
      .LIVES        (LV),
      .NUM_BRICKS   (NB),
      .SERVE_FRAMES (SF),
      .PAUSE_FRAMES (PF),
      .SCORE_W      (SW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .frameTick  (frameTick),
      .launchBtn  (launchBtn),
      .brickHit   (brickHit),
      .ballMissed (ballMissed),
      .gameState  (gameState),
      .ballEnable (ballEnable),
      .ballServe  (ballServe),
      .wallReload (wallReload),
      .livesLeft  (livesLeft),
      .score      (score),
      .bricksLeft (bricksLeft),
      .speedLevel (speedLevel)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Game model: phase number, lives, score, bricks, frames seen in the current phase.
   int m_state, m_lives, m_score, m_bricks, m_frames, m_speed;
   bit m_prev, m_en, m_serve, m_reload;

   typedef struct {
      bit btn, tick, hit, miss;
      int st, en, srv, rel, lives, score, bricks;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(bit b, bit t, bit h, bit m, int st, int en, int srv, int rel,
                               int lv, int sc, int br);
      vec_t v;
      v = '{btn: b, tick: t, hit: h, miss: m, st: st, en: en, srv: srv, rel: rel,
            lives: lv, score: sc, bricks: br};
      return v;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d cycle=%0d", name, got, exp, cyc);
      end
   endtask

   task automatic model_reset(input bit btn);
      m_state = 0; m_lives = LV; m_score = 0; m_bricks = NB; m_frames = 0; m_speed = 0;
      m_prev = btn; m_en = 0; m_serve = 0; m_reload = 0;
   endtask

   task automatic model_step(input bit btn, input bit tick, input bit hit, input bit miss);
      bit press;
      press  = btn && !m_prev;
      m_prev = btn;
      m_serve = 0;
      m_reload = 0;
      case (m_state)
         0: if (press) begin
               m_state = 1; m_reload = 1; m_serve = 1; m_lives = LV; m_score = 0;
               m_bricks = NB; m_speed = 0; m_frames = 0;
            end
         1: if (press) begin
               m_state = 2; m_frames = 0;
            end else if (tick) begin
               m_frames++;
               if (m_frames == SF) begin m_state = 2; m_frames = 0; end
            end
         2: begin
               if (hit) begin
                  if (m_score < SMAX) begin
                     m_score++;
                     if (m_score % 8 == 0 && m_speed < 3) m_speed++;
                  end
                  if (m_bricks > 0) m_bricks--;
                  if (m_bricks == 0) begin m_state = 4; m_reload = 1; m_frames = 0; end
               end
               if (miss && m_state == 2) begin
                  m_lives--;
                  m_state = (m_lives == 0) ? 5 : 3;
                  m_frames = 0;
               end
            end
         3: if (tick) begin
               m_frames++;
               if (m_frames == PF) begin m_serve = 1; m_state = 1; m_frames = 0; end
            end
         4: if (tick) begin
               m_frames++;
               if (m_frames == SF) begin
                  m_serve = 1; m_state = 1; m_frames = 0; m_bricks = NB;
               end
            end
         5: if (press) begin m_state = 0; m_score = 0; end
         default: m_state = 0;
      endcase
      m_en = (m_state == 2);
   endtask

   function automatic int exp_speed();
`ifdef LEVEL_SPEEDUP_EN
      return m_speed;
`else
      return 0;
`endif
   endfunction

   task automatic compare_model();
      chk("gameState", int'(gameState), m_state);
      chk("ballEnable", int'(ballEnable), int'(m_en));
      chk("ballServe", int'(ballServe), int'(m_serve));
      chk("wallReload", int'(wallReload), int'(m_reload));
      chk("livesLeft", int'(livesLeft), m_lives);
      chk("score", int'(score), m_score);
      chk("bricksLeft", int'(bricksLeft), m_bricks);
      chk("speedLevel", int'(speedLevel), exp_speed());
   endtask

   // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
   task automatic cycle(input bit rst, input bit btn, input bit tick, input bit hit,
                        input bit miss);
      reset = rst; launchBtn = btn; frameTick = tick; brickHit = hit; ballMissed = miss;
      @(posedge clock);
      if (rst) model_reset(btn);
      else model_step(btn, tick, hit, miss);
      cyc++;
      #1;
      compare_model();
   endtask

   initial begin
      bit btn_lvl;

      // Vector table: serve timing, hits, miss/pause, early launch, hit+miss together.
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 3, 0, 32));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 32));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 3, 0, 32));
      tbl.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0, 3, 0, 32));
      for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, 3, i, 32 - i));
      tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 2, 5, 27));
      tbl.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0, 2, 5, 27));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 2, 5, 27));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 5, 27));
      tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 2, 5, 27));
      tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0, 2, 5, 27));
      tbl.push_back(mk(0, 1, 1, 1, 3, 0, 0, 0, 1, 6, 26));

      // Reset with button released.
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("rst_state", int'(gameState), 0);
      chk("rst_enable", int'(ballEnable), 0);
      chk("rst_serve", int'(ballServe), 0);
      chk("rst_reload", int'(wallReload), 0);
      chk("rst_lives", int'(livesLeft), LV);
      chk("rst_score", int'(score), 0);
      chk("rst_bricks", int'(bricksLeft), NB);
      chk("rst_speed", int'(speedLevel), 0);

      foreach (tbl[i]) begin
         cycle(0, tbl[i].btn, tbl[i].tick, tbl[i].hit, tbl[i].miss);
         chk("tbl_state", int'(gameState), tbl[i].st);
         chk("tbl_enable", int'(ballEnable), tbl[i].en);
         chk("tbl_serve", int'(ballServe), tbl[i].srv);
         chk("tbl_reload", int'(wallReload), tbl[i].rel);
         chk("tbl_lives", int'(livesLeft), tbl[i].lives);
         chk("tbl_score", int'(score), tbl[i].score);
         chk("tbl_bricks", int'(bricksLeft), tbl[i].bricks);
      end

      // Last life: pause, full serve (done tick in MISS does not count in SERVE), OVER.
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      chk("seqA_serve_state", int'(gameState), 1);
      chk("seqA_serve_pulse", int'(ballServe), 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
      chk("seqA_still_serve", int'(gameState), 1);
      cycle(0, 0, 1, 0, 0);
      chk("seqA_play", int'(gameState), 2);
      cycle(0, 0, 0, 0, 1);
      chk("seqA_over", int'(gameState), 5);
      chk("seqA_lives0", int'(livesLeft), 0);
      cycle(0, 0, 1, 1, 0);
      chk("seqA_over_hit_ignored", int'(score), 6);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
      chk("seqA_over_hold", int'(gameState), 5);
      cycle(0, 1, 0, 0, 0);
      chk("seqA_idle", int'(gameState), 0);
      cycle(0, 0, 0, 0, 0);

      // Clear the wall: saturating score, speed ramp, win on simultaneous hit+miss.
      cycle(0, 1, 0, 0, 0);
      chk("seqB_serve", int'(gameState), 1);
      chk("seqB_lives", int'(livesLeft), LV);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);
`ifdef LEVEL_SPEEDUP_EN
      chk("seqB_speed8", int'(speedLevel), 1);
`else
      chk("seqB_speed8", int'(speedLevel), 0);
`endif
      for (int i = 0; i < 23; i++) cycle(0, 0, 0, 1, 0);
      chk("seqB_bricks1", int'(bricksLeft), 1);
      chk("seqB_score_sat", int'(score), SMAX);
      cycle(0, 0, 1, 1, 1);
      chk("seqB_win", int'(gameState), 4);
      chk("seqB_win_reload", int'(wallReload), 1);
      chk("seqB_win_lives", int'(livesLeft), LV);
      chk("seqB_win_score", int'(score), SMAX);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
      chk("seqB_win_hold", int'(gameState), 4);
      cycle(0, 0, 1, 0, 0);
      chk("seqB_reserve", int'(gameState), 1);
      chk("seqB_reserve_pulse", int'(ballServe), 1);
      chk("seqB_refill", int'(bricksLeft), NB);
      cycle(0, 0, 0, 1, 1);
      chk("seqB_serve_hit_ignored", int'(bricksLeft), NB);

      // Reset mid-MISS with the button held: no press until release and re-press.
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1);
      chk("seqC_miss", int'(gameState), 3);
      cycle(0, 0, 1, 0, 0);
      cycle(1, 1, 0, 0, 0);
      chk("seqC_rst_state", int'(gameState), 0);
      chk("seqC_rst_lives", int'(livesLeft), LV);
      chk("seqC_rst_bricks", int'(bricksLeft), NB);
      chk("seqC_rst_score", int'(score), 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
      chk("seqC_held_idle", int'(gameState), 0);
      cycle(0, 0, 0, 0, 0);
      chk("seqC_release_idle", int'(gameState), 0);
      cycle(0, 1, 0, 0, 0);
      chk("seqC_press_serve", int'(gameState), 1);
      chk("seqC_press_reload", int'(wallReload), 1);

      // Randomized play against the model.
      btn_lvl = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         bit r;
         r = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 7) == 0) btn_lvl = ~btn_lvl;
         cycle(r, btn_lvl, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 24) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
Game-level sequencer for the Breakout ball/bricks datapath. Owns the play state machine, lives, score and brick count. Drives ball enable/re-serve and brick-wall reload strobes into the ball/bricks object block, and consumes its hit/miss events. Runs on the 100 MHz system clock and advances timed phases only on the per-frame tick derived from VGA_Sync.

Parameters:
LIVES, 3, balls per game (1..7)
NUM_BRICKS, 32, bricks in a full wall (1..255)
SERVE_FRAMES, 60, frames held in SERVE before the ball is released (1..255)
PAUSE_FRAMES, 90, frames held in MISS after a lost ball (1..255)
SCORE_W, 12, score counter width

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high
frameTick  in  1  one-cycle pulse per frame (start of vertical blank)
launchBtn  in  1  debounced, level; start/serve request
brickHit  in  1  one-cycle pulse, a brick was destroyed
ballMissed  in  1  one-cycle pulse, ball passed below the paddle
gameState  out  3  current FSM state encoding
ballEnable  out  1  ball motion allowed
ballServe  out  1  one-cycle pulse: re-centre ball on paddle
wallReload  out  1  one-cycle pulse: restore all bricks
livesLeft  out  3  remaining balls
score  out  SCORE_W  bricks destroyed this game, saturating
bricksLeft  out  8  bricks remaining in the current wall
speedLevel  out  2  ball speed select (0 when feature is off)

Behaviour:
- Reset: state IDLE; ballEnable=0, ballServe=0, wallReload=0, livesLeft=LIVES, score=0, bricksLeft=NUM_BRICKS, speedLevel=0, frame counter=0.
- States: IDLE=0, SERVE=1, PLAY=2, MISS=3, WIN=4, OVER=5. Outputs are registered; every strobe lasts exactly one clock.
- launchBtn is edge-detected (rising edge = press). A level held through reset is not a press.
- IDLE: on press -> SERVE; same cycle pulse wallReload and ballServe; livesLeft<=LIVES, score<=0, bricksLeft<=NUM_BRICKS, frame counter<=0.
- SERVE: ballEnable=0. Frame counter increments on frameTick. When it reaches SERVE_FRAMES, or on a press (early launch), -> PLAY; counter<=0.
- PLAY: ballEnable=1.
  - brickHit: score+1, saturating at all-ones. bricksLeft-1, never below 0. If bricksLeft was 1 -> WIN.
  - ballMissed: livesLeft-1. If livesLeft was 1 -> OVER, else -> MISS.
  - brickHit and ballMissed in the same cycle: the hit is applied first. If it clears the wall, WIN takes priority and no life is lost.
- MISS: ballEnable=0. Count PAUSE_FRAMES frameTicks, then pulse ballServe and -> SERVE.
- WIN: ballEnable=0. Pulse wallReload on entry. Wait SERVE_FRAMES frameTicks, then pulse ballServe, set bricksLeft<=NUM_BRICKS, -> SERVE. Score and lives are kept.
- OVER: ballEnable=0. Hold until a press, then -> IDLE. Score stays visible until that press.
- hit/miss pulses outside PLAY are ignored.
- frameTick coincident with a state transition does not count toward the new state.
- A synchronous reset in any state returns everything to reset values on the next edge. Strobes in flight are dropped.

Optional Feature:
LEVEL_SPEEDUP_EN
- Defined: speedLevel increments, saturating at 3, each time 8 further bricks are destroyed in a game (score[2:0] rolls to 0 on a hit). speedLevel resets to 0 on IDLE->SERVE. It is not reset by MISS or WIN.
- Undefined: speedLevel is tied to 0 and no extra logic is built.

Decomposition:
- Shared package breakout_pkg holds the state encoding typedef/localparams, SCORE_W and NUM_BRICKS defaults, and the strobe widths shared with the ball/bricks object block.
- One sub-module: frame_delay_timer. Loadable 8-bit frame counter, counts on frameTick, gives a one-cycle done pulse. It is reused by the SERVE, MISS and WIN states.

Test Plan:
- Reset then one press, SERVE_FRAMES=4 -> wallReload and ballServe high for one clock each; gameState=1; ballEnable rises after exactly 4 frameTicks; gameState=2.
- In PLAY, 5 brickHit pulses -> score=5, bricksLeft=27. With the macro defined, 8 hits -> speedLevel=1.
- 3 ballMissed in PLAY (LIVES=3, PAUSE_FRAMES=2) -> after each of the first two: MISS, then ballServe after 2 ticks, then SERVE. Third miss -> OVER, livesLeft=0. Press -> IDLE.
- NUM_BRICKS=2, hit twice -> WIN, wallReload pulse, then SERVE; bricksLeft=2, score=2, livesLeft unchanged.
- bricksLeft=1 with brickHit and ballMissed in the same cycle -> WIN, livesLeft unchanged. bricksLeft=5 with both in the same cycle -> bricksLeft=4, MISS.
- Reset asserted mid-MISS, and launchBtn held high across reset -> all outputs at reset values; state remains IDLE until the button is released and pressed again.
